// File: rtl/dmac_pkg.sv
// Shared constants and state encoding for the result-FIFO drain engine.
package dmac_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned CNT_W   = 5;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWait = 3'd1,
    StPop  = 3'd2,
    StCap  = 3'd3,
    StReq  = 3'd4,
    StWr   = 3'd5,
    StDone = 3'd6
  } state_e;

endpackage

// File: rtl/dmac_drain_ns.sv
// Combinational next-state logic for the FIFO drain engine.
module dmac_drain_ns
  import dmac_pkg::*;
(
  input  state_e state,
  input  logic   start,
  input  logic   len_ok,
  input  logic   f_empty,
  input  logic   f_rd_ack,
  input  logic   f_rd_err,
  input  logic   m_grant,
  input  logic   cnt_eq,
  output state_e state_nxt
);

  logic unused_rd_err;

  // A missing ack is treated like a read error, so f_rd_err needs no separate path.
  assign unused_rd_err = f_rd_err;

  // Next-state decode; illegal encodings fall back to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      StIdle: begin
        // Rejected lengths report through the done pulse with no transfer.
        if (start) state_nxt = len_ok ? StWait : StDone;
      end
      StWait: if (!f_empty) state_nxt = StPop;
      StPop:  state_nxt = StCap;
      StCap:  state_nxt = f_rd_ack ? StReq : StDone;
      StReq:  if (m_grant) state_nxt = StWr;
      StWr:   state_nxt = cnt_eq ? StDone : StWait;
      StDone: state_nxt = StIdle;
      default: state_nxt = StIdle;
    endcase
  end

endmodule

// File: rtl/dmac_fifo_drain.sv
// Drains a programmed number of words from the result FIFO onto the memory bus.
module dmac_fifo_drain
  import dmac_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  length,
  input  logic              f_empty,
  input  logic              f_rd_ack,
  input  logic              f_rd_err,
  input  logic [DATA_W-1:0] f_rdata,
  output logic              f_rd_en,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  words_done
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, addr_q;
  logic [CNT_W-1:0]   len_q, words_done_q, wd_inc;
  logic [DATA_W-1:0]  data_q, dout_q;
  logic               err_q;
  logic               len_ok, cnt_eq;

  assign len_ok = (length != '0) && (length <= CNT_W'(MAX_LEN));
  assign wd_inc = words_done_q + 1'b1;
  assign cnt_eq = (wd_inc == len_q);

  dmac_drain_ns u_ns (
    .state     (state_q),
    .start     (start),
    .len_ok    (len_ok),
    .f_empty   (f_empty),
    .f_rd_ack  (f_rd_ack),
    .f_rd_err  (f_rd_err),
    .m_grant   (m_grant),
    .cnt_eq    (cnt_eq),
    .state_nxt (state_d)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Transfer parameters, captured data, bus output holding registers and status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q       <= '0;
      len_q        <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      dout_q       <= '0;
      words_done_q <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            if (len_ok) begin
              base_q       <= base_addr;
              len_q        <= length;
              words_done_q <= '0;
              err_q        <= 1'b0;
            end else begin
              // Zero length is a benign no-op; oversize is an error.
              err_q <= (length != '0);
            end
          end
        end
        StCap: begin
          if (f_rd_ack) data_q <= f_rdata;
          else          err_q  <= 1'b1;
        end
        StReq: begin
          // Load the bus outputs on grant so they are stable for the whole WR cycle
          // and keep their values afterwards.
          if (m_grant) begin
            addr_q <= base_q + ADDR_W'(words_done_q);
            dout_q <= data_q;
          end
        end
        StWr: words_done_q <= wd_inc;
        default: ;
      endcase
    end
  end

  // Output decode straight from state so reset drops them without a clock.
  always_comb begin
    f_rd_en    = (state_q == StPop);
    m_req      = (state_q == StReq) || (state_q == StWr);
    m_wr       = (state_q == StWr);
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    err        = err_q;
    words_done = words_done_q;
    m_addr     = addr_q;
    m_dout     = dout_q;
  end

endmodule

// File: tb/tb_dmac_fifo_drain.sv
// Scoreboard bench for dmac_fifo_drain: stimulus pushes expected writes/completions,
// a monitor pops and compares them as the DUT produces them.
module tb_dmac_fifo_drain;
  import dmac_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  length = '0;
  logic              f_empty = 1'b1;
  logic              f_rd_ack = 1'b0;
  logic              f_rd_err = 1'b0;
  logic [DATA_W-1:0] f_rdata = '0;
  logic              f_rd_en;
  logic              m_req;
  logic              m_grant = 1'b1;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dout;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  words_done;

  dmac_fifo_drain dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .f_empty    (f_empty),
    .f_rd_ack   (f_rd_ack),
    .f_rd_err   (f_rd_err),
    .f_rdata    (f_rdata),
    .f_rd_en    (f_rd_en),
    .m_req      (m_req),
    .m_grant    (m_grant),
    .m_wr       (m_wr),
    .m_addr     (m_addr),
    .m_dout     (m_dout),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_done (words_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          gap;   // expected cycles since previous start/write, 0 = don't care
  } wr_t;

  typedef struct {
    logic [4:0] wd;
    logic       chk_wd;
    logic       err;
    logic       chk_gap; // done must follow the last write by exactly one cycle
  } dn_t;

  wr_t         wq[$];
  dn_t         dq[$];
  logic [31:0] fq[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_evt = 0;
  int          pop_cnt = 0;
  int          err_at = 0;
  int          stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO read-port model: responds the cycle after a pop; err_at injects a read error.
  always @(posedge clk) begin
    f_rd_ack <= 1'b0;
    f_rd_err <= 1'b0;
    if (f_rd_en) begin
      pop_cnt <= pop_cnt + 1;
      if ((pop_cnt + 1 == err_at) || (fq.size() == 0)) begin
        f_rd_err <= 1'b1;
      end else begin
        f_rd_ack <= 1'b1;
        f_rdata  <= fq.pop_front();
      end
    end
    if (m_req && !m_grant) stall_cnt <= stall_cnt + 1;
  end

  always @(negedge clk) f_empty <= (fq.size() == 0);

  // Monitor: compares every write and completion against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (f_rd_en) chk("rd_en_while_empty", 32'(f_empty), 0);
      if (m_wr) begin
        chk("wr_queued", 32'(wq.size() != 0), 1);
        if (wq.size() != 0) begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", 32'(m_addr), 32'(w.addr));
          chk("wr_data", m_dout, w.data);
          if (w.gap != 0) chk("wr_gap", cyc - last_evt, w.gap);
        end
        last_evt = cyc;
      end
      if (done) begin
        chk("done_queued", 32'(dq.size() != 0), 1);
        if (dq.size() != 0) begin
          dn_t d;
          d = dq.pop_front();
          chk("done_err", 32'(err), 32'(d.err));
          if (d.chk_wd) chk("done_words", 32'(words_done), 32'(d.wd));
          if (d.chk_gap) chk("done_gap", cyc - last_evt, 1);
        end
      end
    end
  end

  task automatic exp_wr(input logic [7:0] a, input logic [31:0] d, input int gap);
    wr_t w;
    w.addr = a; w.data = d; w.gap = gap;
    wq.push_back(w);
  endtask

  task automatic exp_done(input logic [4:0] wd, input logic chk_wd, input logic e,
                          input logic chk_gap);
    dn_t d;
    d.wd = wd; d.chk_wd = chk_wd; d.err = e; d.chk_gap = chk_gap;
    dq.push_back(d);
  endtask

  task automatic do_start(input logic [7:0] b, input logic [4:0] l);
    @(negedge clk);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    last_evt  = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 32'(done), 1);
    @(negedge clk);
    chk("scoreboard_writes_empty", wq.size(), 0);
    chk("scoreboard_done_empty", dq.size(), 0);
  endtask

  task automatic wait_sig_req();
    int k = 0;
    while (!m_req && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("req_seen", 32'(m_req), 1);
  endtask

  initial begin
    int s0, p0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_f_rd_en", 32'(f_rd_en), 0);
    chk("rst_m_req", 32'(m_req), 0);
    chk("rst_m_wr", 32'(m_wr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_words_done", 32'(words_done), 0);
    chk("rst_m_addr", 32'(m_addr), 0);
    chk("rst_m_dout", m_dout, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal: four words, immediate grant, 5-cycle cadence
    for (int i = 0; i < 4; i++) begin
      fq.push_back(32'hA000_0000 + i);
      exp_wr(8'h10 + 8'(i), 32'hA000_0000 + i, 5);
    end
    exp_done(5'd4, 1'b1, 1'b0, 1'b1);
    do_start(8'h10, 5'd4);
    wait_done();
    chk("nom_words_done", 32'(words_done), 4);
    chk("nom_err", 32'(err), 0);
    chk("nom_busy_after", 32'(busy), 0);

    // Grant stall of 3 cycles, then empty FIFO for 4 cycles before word two
    fq.push_back(32'hB000_0000);
    exp_wr(8'h20, 32'hB000_0000, 0);
    exp_wr(8'h21, 32'hB000_0001, 0);
    exp_done(5'd2, 1'b1, 1'b0, 1'b1);
    m_grant = 1'b0;
    s0 = stall_cnt;
    do_start(8'h20, 5'd2);
    wait_sig_req();
    repeat (3) @(negedge clk);
    chk("stall_req_held", 32'(m_req), 1);
    m_grant = 1'b1;
    begin
      int k = 0;
      while (!m_wr && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    repeat (4) @(negedge clk);
    chk("empty_stall_busy", 32'(busy), 1);
    fq.push_back(32'hB000_0001);
    wait_done();
    chk("stall_cycles", stall_cnt - s0, 3);
    chk("stall_words_done", 32'(words_done), 2);

    // Address wrap 0xFE -> 0xFF -> 0x00
    for (int i = 0; i < 3; i++) fq.push_back(32'hC000_0000 + i);
    exp_wr(8'hFE, 32'hC000_0000, 5);
    exp_wr(8'hFF, 32'hC000_0001, 5);
    exp_wr(8'h00, 32'hC000_0002, 5);
    exp_done(5'd3, 1'b1, 1'b0, 1'b1);
    do_start(8'hFE, 5'd3);
    wait_done();

    // Read error on the second pop aborts after one write
    for (int i = 0; i < 3; i++) fq.push_back(32'hD000_0000 + i);
    err_at = pop_cnt + 2;
    exp_wr(8'h30, 32'hD000_0000, 5);
    exp_done(5'd1, 1'b1, 1'b1, 1'b0);
    do_start(8'h30, 5'd3);
    wait_done();
    chk("rderr_words_done", 32'(words_done), 1);
    chk("rderr_err_sticky", 32'(err), 1);
    fq.delete();
    err_at = 0;

    // Illegal lengths: no pops, no writes
    p0 = pop_cnt;
    exp_done(5'd0, 1'b0, 1'b0, 1'b0);
    do_start(8'h40, 5'd0);
    wait_done();
    chk("len0_err", 32'(err), 0);
    exp_done(5'd0, 1'b0, 1'b1, 1'b0);
    do_start(8'h40, 5'd17);
    wait_done();
    chk("len17_err", 32'(err), 1);
    chk("illegal_no_pops", pop_cnt - p0, 0);

    // Asynchronous reset while stalled in REQ
    fq.push_back(32'hE000_0000);
    m_grant = 1'b0;
    do_start(8'h40, 5'd1);
    wait_sig_req();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_m_req", 32'(m_req), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_f_rd_en", 32'(f_rd_en), 0);
    chk("arst_m_wr", 32'(m_wr), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_words_done", 32'(words_done), 0);
    chk("arst_m_addr", 32'(m_addr), 0);
    chk("arst_m_dout", m_dout, 0);
    repeat (2) @(negedge clk);
    fq.delete();
    m_grant = 1'b1;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal transfer after reset
    fq.push_back(32'hF000_0000);
    fq.push_back(32'hF000_0001);
    exp_wr(8'h50, 32'hF000_0000, 5);
    exp_wr(8'h51, 32'hF000_0001, 5);
    exp_done(5'd2, 1'b1, 1'b0, 1'b1);
    do_start(8'h50, 5'd2);
    wait_done();
    chk("post_rst_words_done", 32'(words_done), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dmac_fifo_drain.md
# dmac_fifo_drain

Consumer-side engine for the 16-entry, 32-bit result FIFO in the ALU-DMAC datapath. On a start command it pops a programmed number of words from the FIFO, one at a time. It writes each word to consecutive addresses on the memory bus using a request/grant handshake, then signals completion. It sits between the result FIFO's read port and the DMAC memory-bus master port.

## Interface
- DATA_W, 32, FIFO and bus data width
- ADDR_W, 8, bus address width
- MAX_LEN, 16, maximum words per transfer (FIFO depth)

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle command pulse; sampled only in IDLE
- base_addr  in  ADDR_W  destination base address, latched on accepted start
- length  in  5  words to transfer, latched on accepted start; legal range 1..MAX_LEN
- f_empty  in  1  FIFO empty flag
- f_rd_ack  in  1  FIFO read acknowledge, valid the cycle after rd_en
- f_rd_err  in  1  FIFO read error (read while empty), valid the cycle after rd_en
- f_rdata  in  DATA_W  FIFO read data, valid with f_rd_ack
- f_rd_en  out  1  FIFO pop request, one-cycle pulse
- m_req  out  1  bus request
- m_grant  in  1  bus grant
- m_wr  out  1  bus write strobe, one cycle per word
- m_addr  out  ADDR_W  bus write address
- m_dout  out  DATA_W  bus write data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag; cleared on next accepted start
- words_done  out  5  words written in current or last transfer

## Operation
- States: IDLE, WAIT, POP, CAP, REQ, WR, DONE (3-bit encoding).
- IDLE:
  - start=1 with length in 1..MAX_LEN: latch base_addr and length, clear words_done and err, go to WAIT.
  - length=0: go to DONE, err=0.
  - length>MAX_LEN: set err, go to DONE.
  - No transfer occurs in either rejected case.
  - start is ignored in every other state.
- WAIT: if f_empty=0, go to POP; otherwise stay.
- POP: f_rd_en=1 for exactly this cycle, then go to CAP.
- CAP:
  - f_rd_ack=1: latch f_rdata into the data register, go to REQ.
  - f_rd_err=1 (or neither ack nor err): set err, go to DONE (abort). words_done keeps its count.
- REQ: m_req=1; on m_grant=1, go to WR.
- WR:
  - m_req=1, m_wr=1, m_addr=base_addr+words_done (mod 2^ADDR_W, so the address wraps 0xFF->0x00), m_dout=data register.
  - words_done increments.
  - If the incremented value equals length, go to DONE; otherwise go to WAIT.
- DONE: done=1 for one cycle, then go to IDLE.
- Outputs are decoded from state: f_rd_en in POP, m_req in REQ/WR, m_wr in WR, busy in every state except IDLE.
- m_addr/m_dout hold their last values outside WR.

## Timing
- Reset (async, immediate):
  - state=IDLE.
  - f_rd_en=0, m_req=0, m_wr=0, busy=0, done=0, err=0.
  - words_done=0, m_addr=0, m_dout=0, latched length/base/data=0.
- Reset asserted mid-transfer aborts the transfer. Outputs drop asynchronously, without waiting for clk. No done pulse.
- Minimum per-word cost is 5 cycles (WAIT, POP, CAP, REQ, WR), reached when the FIFO is non-empty and grant is immediate.
- start to first m_wr: minimum 5 cycles. Last m_wr to done: 1 cycle.
- m_grant low stalls in REQ indefinitely; no timeout.
- Empty FIFO stalls in WAIT indefinitely. f_rd_en is never issued while f_empty=1.

## Structure
- Shared package dmac_pkg:
  - state encoding constants
  - DATA_W, ADDR_W, MAX_LEN, CNT_W=5
- One sub-module: dmac_drain_ns, the combinational next-state logic. Inputs: state, start, length check, f_empty, f_rd_ack, f_rd_err, m_grant, count-equal. Output: next state.
- Top level holds the state, counter, address and data registers and the output decode.

## Test plan
- Nominal transfer, immediate grant:
  - Stimulus: FIFO preloaded with 0xA0000000..0xA0000003, start with base=0x10, length=4.
  - Response: four m_wr at 0x10..0x13 carrying matching data, 5 cycles apart; done pulse 1 cycle after the last m_wr; words_done=4; err=0.
- Grant stall and empty stall:
  - Stimulus: length=2; m_grant held low 3 cycles; FIFO empty for 4 cycles before the second word.
  - Response: m_req stays high through the stall; f_rd_en is never asserted while f_empty=1; both writes complete.
- Address wrap:
  - Stimulus: base=0xFE, length=3.
  - Response: m_addr sequence 0xFE, 0xFF, 0x00.
- Read error abort:
  - Stimulus: f_rd_err=1 in CAP on the second word of length=3.
  - Response: err=1, done pulse, exactly one m_wr, words_done=1.
- Illegal length:
  - Stimulus: start with length=0.
  - Response: done without any m_wr, err=0.
  - Stimulus: start with length=17.
  - Response: done without any m_wr, err=1.
- Reset mid-transfer:
  - Stimulus: reset_n low while in REQ.
  - Response: m_req, busy and f_rd_en drop without waiting for a clock edge; all outputs at reset values; next start runs normally.
